// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and timing constants shared by the UART path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SB_1       = 16;
    localparam int SB_1P5     = 24;
    localparam int SB_2       = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 16x-oversampled serialiser (start, DBIT data bits LSB first, stop).
// Defining UART_TX_PARITY_EN inserts an even parity bit after the last data bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = SB_1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

    uart_state_t state_reg, state_next;
    logic [4:0]  s_reg, s_next;
    logic [2:0]  n_reg, n_next;
    logic [7:0]  b_reg, b_next;
    logic        tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic        p_reg, p_next;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= 5'd0;
            n_reg     <= 3'd0;
            b_reg     <= 8'd0;
            tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
            p_reg     <= p_next;
`endif
        end
    end

    // Next-state, line level and done pulse
    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        tx_next      = 1'b1;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        p_next       = p_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    state_next = ST_START;
                    s_next     = 5'd0;
                    b_next     = din;
`ifdef UART_TX_PARITY_EN
                    p_next     = 1'b0;
`endif
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (s_reg == TICK_LAST) begin
                        state_next = ST_DATA;
                        s_next     = 5'd0;
                        n_next     = 3'd0;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end else begin
                    s_next = s_reg;
                end
            end
            ST_DATA: begin
                tx_next = b_reg[0];
                if (s_tick) begin
                    if (s_reg == TICK_LAST) begin
                        s_next = 5'd0;
                        b_next = {1'b0, b_reg[7:1]};
`ifdef UART_TX_PARITY_EN
                        p_next = parity_step(p_reg, b_reg[0]);
`endif
                        if (n_reg == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end else begin
                    s_next = s_reg;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_next = p_reg;
                if (s_tick) begin
                    if (s_reg == TICK_LAST) begin
                        state_next = ST_STOP;
                        s_next     = 5'd0;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end else begin
                    s_next = s_reg;
                end
            end
`endif
            ST_STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        state_next   = ST_IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end else begin
                    s_next = s_reg;
                end
            end
            // Unreachable encodings fall back to idle with the line released
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx_busy = (state_reg != ST_IDLE);
    assign tx      = tx_reg;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmitter for the UART path.
- Consumes the 16x-oversampling baud tick (s_tick) from the external mod-M baud tick generator.
- Serialises a parallel byte as start bit, LSB-first data bits, optional parity bit, then stop bit(s).
- Sits between the TX FIFO/host logic and the pad; the receiver's counterpart on the same line.

Parameters:
- DBIT, 8, number of data bits per frame (legal 5..8).
- SB_TICK, 16, s_ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  one-clk-wide enable pulse at 16x baud rate.
- tx_start  input  1  request to send din; sampled only in idle.
- din  input  8  byte to send; bits [DBIT-1:0] used, sampled on accepted tx_start.
- tx_busy  output  1  high whenever state != idle.
- tx_done_tick  output  1  one-clk pulse at frame end.
- tx  output  1  serial line, registered, idle-high.

Behaviour:
- Registers:
  - state (idle/start/data/parity/stop)
  - s_reg: 5-bit tick count, wide enough for SB_TICK-1 = 31
  - n_reg: 3-bit data bit count
  - b_reg: 8-bit shift register
  - p_reg: parity accumulator
  - tx_reg
- Async reset: state=idle, s_reg=0, n_reg=0, b_reg=0, p_reg=0, tx_reg=1. Outputs go to tx=1, tx_busy=0, tx_done_tick=0 immediately, regardless of frame progress.
- tx = tx_reg. tx_next is 1 in idle/stop, 0 in start, b_reg[0] in data, p_reg in parity. tx therefore lags a state change by one clk.
- idle:
  - tx_start=1 -> b_reg<=din, s_reg<=0, p_reg<=0, go start.
  - s_tick is irrelevant in idle.
- start:
  - On s_tick: if s_reg==15 then s_reg<=0, n_reg<=0, go data; else s_reg+1.
  - Start bit lasts exactly 16 ticks.
- data:
  - On s_tick with s_reg==15: s_reg<=0, p_reg<=p_reg^b_reg[0], b_reg<=b_reg>>1.
  - Then, if n_reg==DBIT-1, go parity (macro defined) or stop; else n_reg+1.
  - Otherwise on s_tick: s_reg+1.
- parity (macro only):
  - On s_tick: if s_reg==15 then s_reg<=0, go stop; else s_reg+1.
- stop:
  - On s_tick: if s_reg==SB_TICK-1 then go idle and assert tx_done_tick; else s_reg+1.
- tx_done_tick is Mealy: high for the single clk where state=stop, s_tick=1 and s_reg==SB_TICK-1.
- tx_start outside idle is ignored entirely, including in the done-tick cycle. The earliest accepted restart is the first clk in idle.
- din is not required to stay stable after acceptance.
- Frame length in ticks: 16 + 16*DBIT (+16 with parity) + SB_TICK. 8N1 = 160 ticks.
- s_tick absent means the FSM holds its state indefinitely.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: parity state inserted after the last data bit. It transmits even parity (XOR of the DBIT data bits) for 16 ticks.
- Undefined: parity state, p_reg and its logic are not compiled; data goes directly to stop.

Decomposition:
- uart_pkg holds:
  - state enum encoding (idle=0, start=1, data=2, parity=3, stop=4, 3 bits)
  - OVERSAMPLE=16 constant
  - stop-tick constants SB_1=16, SB_1P5=24, SB_2=32
- No sub-module inside the block; the baud tick generator stays external and shared with the receiver.

Test Plan:
- 8N1, s_tick every 4 clk, din=8'hA5, tx_start pulse -> tx = 0, then 1,0,1,0,0,1,0,1, then 1; each bit held 16 ticks. tx_done_tick single pulse at tick 160; tx_busy low the following clk.
- tx_start=1 with din=8'h3C at tick 40 of a frame in flight -> ignored; the transmitted byte stays 8'hA5 and no second frame starts.
- reset asserted at tick 70 (data bit 3) -> tx=1 and tx_busy=0 same cycle, no tx_done_tick. After release, a new tx_start sends a clean frame.
- SB_TICK=32, din=8'hFF -> stop level high for 32 ticks; tx_done_tick at tick 176.
- Back-to-back: tx_start in the first idle clk after tx_done_tick, din=8'h00 -> tx falls one clk later; no idle gap beyond 1 clk.
- UART_TX_PARITY_EN defined, din=8'h07 -> parity bit=1 after bit 7; frame 176 ticks. With din=8'h03 -> parity bit=0.
